axi_lite_sram_bridge: RTL and testbench

AXI4-Lite slave that converts single-beat AXI read and write transactions into single-cycle chip-select accesses on the 32-bit word SRAM that sits directly downstream. It owns all handshaking, address decode and error responses. The SRAM sees only `cs`, `we`, `addr` and `din`, and returns registered `dout` one cycle after a read strobe. One transaction is in flight at a time.

---
 rtl/axi_sram_pkg.sv | 25 ++
 rtl/axi_sram_addr_dec.sv | 26 ++
 rtl/axi_lite_sram_bridge.sv | 182 ++++++++++++++++++
 tb/tb_axi_lite_sram_bridge.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Shared constants and types for the AXI4-Lite to word-SRAM bridge.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only full-word writes reach the SRAM; any other byte mask is rejected.
  localparam logic [3:0] STRB_FULL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    BRESP,
    RD,
    RCAP,
    RRESP
  } state_t;

  function automatic logic strb_ok(input logic [3:0] strb);
    return strb == STRB_FULL;
  endfunction

endpackage

// File: rtl/axi_sram_addr_dec.sv
// Byte address to SRAM word index decoder with range/alignment error flag.
// Latency: purely combinational.
// Backpressure: not applicable.
module axi_sram_addr_dec #(
  parameter int ADDR_W    = 12,
  parameter int MEM_AW    = 8,
  parameter int MEM_DEPTH = 8
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [MEM_AW-1:0] o_idx,
  output logic              o_err
);

  logic w_misaligned;
  logic w_high_bits;
  logic w_past_depth;

  assign o_idx        = i_addr[MEM_AW+1:2];
  assign w_misaligned = (i_addr[1:0] != 2'b00);
  // Bits above the word index must be clear, otherwise the address aliases.
  assign w_high_bits  = (i_addr[ADDR_W-1:MEM_AW+2] != '0);
  // The index field can address more words than are actually implemented.
  assign w_past_depth = (32'(o_idx) >= 32'(MEM_DEPTH));
  assign o_err        = w_misaligned | w_high_bits | w_past_depth;

endmodule

// File: rtl/axi_lite_sram_bridge.sv
// AXI4-Lite slave turning single-beat reads/writes into one-cycle SRAM strobes.
// Latency: write OK resp 2 cycles after handshake, read OK 3, any error 1.
// Backpressure: one transaction in flight; responses held until bready/rready.
module axi_lite_sram_bridge
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MEM_AW    = 8,
  parameter int MEM_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  state_t              r_state;
  logic                r_last_wr;
  logic [1:0]          r_bresp;
  logic                r_bvalid;
  logic [1:0]          r_rresp;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_sram_cs;
  logic                r_sram_we;
  logic [MEM_AW-1:0]   r_sram_addr;
  logic [DATA_W-1:0]   r_sram_din;

  logic [MEM_AW-1:0]   w_aw_idx;
  logic                w_aw_err;
  logic [MEM_AW-1:0]   w_ar_idx;
  logic                w_ar_err;
  logic                w_idle;
  logic                w_wr_pend;
  logic                w_sel_wr;
  logic                w_sel_rd;
  logic                w_wr_err;

  axi_sram_addr_dec #(
    .ADDR_W    (ADDR_W),
    .MEM_AW    (MEM_AW),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_aw_dec (
    .i_addr (s_awaddr),
    .o_idx  (w_aw_idx),
    .o_err  (w_aw_err)
  );

  axi_sram_addr_dec #(
    .ADDR_W    (ADDR_W),
    .MEM_AW    (MEM_AW),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ar_dec (
    .i_addr (s_araddr),
    .o_idx  (w_ar_idx),
    .o_err  (w_ar_err)
  );

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign w_idle    = (r_state == IDLE) && !rst;
  assign w_wr_pend = s_awvalid && s_wvalid;
  // On a tie between write and read, serve whichever type did not go last.
  assign w_sel_wr  = w_idle && w_wr_pend && (!s_arvalid || !r_last_wr);
  assign w_sel_rd  = w_idle && s_arvalid && !w_sel_wr;
  assign w_wr_err  = w_aw_err || !strb_ok(s_wstrb);

  assign s_awready = w_sel_wr;
  assign s_wready  = w_sel_wr;
  assign s_arready = w_sel_rd;

  assign s_bresp   = r_bresp;
  assign s_bvalid  = r_bvalid;
  assign s_rresp   = r_rresp;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign sram_cs   = r_sram_cs;
  assign sram_we   = r_sram_we;
  assign sram_addr = r_sram_addr;
  assign sram_din  = r_sram_din;

  // Transaction FSM; every AXI response and SRAM pin is a registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_wr   <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_bvalid    <= 1'b0;
      r_rresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_sram_cs   <= 1'b0;
      r_sram_we   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_wr) begin
            r_last_wr <= 1'b1;
            if (w_wr_err) begin
              r_bresp  <= RESP_SLVERR;
              r_bvalid <= 1'b1;
              r_state  <= BRESP;
            end else begin
              r_sram_cs   <= 1'b1;
              r_sram_we   <= 1'b1;
              r_sram_addr <= w_aw_idx;
              r_sram_din  <= s_wdata;
              r_state     <= WR;
            end
          end else if (w_sel_rd) begin
            r_last_wr <= 1'b0;
            if (w_ar_err) begin
              r_rresp  <= RESP_SLVERR;
              r_rdata  <= '0;
              r_rvalid <= 1'b1;
              r_state  <= RRESP;
            end else begin
              r_sram_cs   <= 1'b1;
              r_sram_we   <= 1'b0;
              r_sram_addr <= w_ar_idx;
              r_state     <= RD;
            end
          end
        end
        WR: begin
          r_sram_cs <= 1'b0;
          r_sram_we <= 1'b0;
          r_bresp   <= RESP_OKAY;
          r_bvalid  <= 1'b1;
          r_state   <= BRESP;
        end
        BRESP: begin
          if (s_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD: begin
          r_sram_cs <= 1'b0;
          r_state   <= RCAP;
        end
        RCAP: begin
          // SRAM output register holds the word strobed in RD.
          r_rdata  <= sram_dout;
          r_rresp  <= RESP_OKAY;
          r_rvalid <= 1'b1;
          r_state  <= RRESP;
        end
        RRESP: begin
          if (s_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_bridge.sv
module tb_axi_lite_sram_bridge;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int         DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = 4'hF;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        sram_cs;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Downstream SRAM: write on cs&we, registered read data on cs&!we.
  logic [31:0] sram_mem [256] = '{default: 32'h0};

  // Reference model state: memory contents and which type was served last.
  logic [31:0] ref_mem [DEPTH];
  bit          m_last_wr = 1'b0;

  // Monitor results.
  int          wr_strobes = 0;
  int          rd_strobes = 0;
  logic [7:0]  mon_addr = '0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  axi_lite_sram_bridge #(
    .ADDR_W(12), .DATA_W(32), .MEM_AW(8), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= sram_din;
      else         sram_dout <= sram_mem[sram_addr];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (sram_cs && sram_we)  begin wr_strobes++; mon_addr = sram_addr; end
    if (sram_cs && !sram_we) begin rd_strobes++; mon_addr = sram_addr; end
    if (s_bvalid && s_bready) bq.push_back(s_bresp);
    if (s_rvalid && s_rready) rq.push_back({s_rresp, s_rdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // A legal target is a word-aligned byte address inside the implemented words.
  function automatic bit m_addr_ok(input logic [11:0] a);
    return (a % 12'd4 == 12'd0) && (a < 12'(4 * DEPTH));
  endfunction

  function automatic int m_idx(input logic [11:0] a);
    return int'(a) / 4;
  endfunction

  // ---------------- stimulus helpers (no checking beyond bounded waits) ----------

  task automatic issue_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] st, output int hs);
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1; hs = -1;
    for (int i = 0; i < 50 && hs < 0; i++) begin
      @(negedge clk);
      if (s_awready && s_wready) hs = cyc;
    end
    n_tests++;
    if (hs < 0) begin n_fail++; $display("FAIL aw_accept: no awready for addr %h", a); end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    m_last_wr = 1'b1;
  endtask

  task automatic issue_read(input logic [11:0] a, output int hs);
    s_araddr = a; s_arvalid = 1'b1; hs = -1;
    for (int i = 0; i < 50 && hs < 0; i++) begin
      @(negedge clk);
      if (s_arready) hs = cyc;
    end
    n_tests++;
    if (hs < 0) begin n_fail++; $display("FAIL ar_accept: no arready for addr %h", a); end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    m_last_wr = 1'b0;
  endtask

  // Cycles after the handshake edge until valid is seen (99 = never).
  task automatic wait_b(output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); lat++;
      if (s_bvalid) seen = 1'b1;
    end
    if (!seen) lat = 99;
  endtask

  task automatic wait_r(output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); lat++;
      if (s_rvalid) seen = 1'b1;
    end
    if (!seen) lat = 99;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] resp, output int lat, output int nstb);
    int hs;
    int w0 = wr_strobes;
    bq.delete();
    issue_write(a, d, st, hs);
    wait_b(lat);
    @(posedge clk); #1;
    resp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    nstb = wr_strobes - w0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [1:0] resp,
                         output logic [31:0] d, output int lat, output int nstb);
    int hs;
    int r0 = rd_strobes;
    rq.delete();
    issue_read(a, hs);
    wait_r(lat);
    @(posedge clk); #1;
    if (rq.size() > 0) {resp, d} = rq.pop_front();
    else begin resp = 2'bxx; d = 'x; end
    nstb = rd_strobes - r0;
  endtask

  // ---------------- scenarios ----------------

  task automatic test_reset();
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    #2 rst = 1'b1;
    #3;
    n_tests++;
    if ({s_awready, s_wready, s_arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 000", {s_awready, s_wready, s_arready});
    end
    n_tests++;
    if ({s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata, sram_cs, sram_we, sram_addr, sram_din} !== 80'd0) begin
      n_fail++; $display("FAIL reset_outputs: bv=%b rv=%b rdata=%h cs=%b addr=%h din=%h",
                         s_bvalid, s_rvalid, s_rdata, sram_cs, sram_addr, sram_din);
    end
    repeat (2) @(posedge clk);
    #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    rst = 1'b0;
    m_last_wr = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({s_bvalid, s_rvalid, sram_cs} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected 000", {s_bvalid, s_rvalid, sram_cs});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [1:0] resp; logic [31:0] d; int lat, nstb;
    do_read(12'h01C, resp, d, lat, nstb);
    n_tests++;
    if ({resp, d, lat, nstb} !== {OKAY, ref_mem[7], 32'd3, 32'd1}) begin
      n_fail++; $display("FAIL read_idx7: resp=%b data=%h lat=%0d strobes=%0d expected %b %h 3 1",
                         resp, d, lat, nstb, OKAY, ref_mem[7]);
    end
    do_read(12'h020, resp, d, lat, nstb);
    n_tests++;
    if ({resp, d, lat, nstb} !== {SLVERR, 32'd0, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL read_idx8: resp=%b data=%h lat=%0d strobes=%0d expected 10 0 1 0",
                         resp, d, lat, nstb);
    end
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [31:0] d; int lat, nstb;
    do_write(12'h004, 32'hDEADBEEF, 4'hF, resp, lat, nstb);
    ref_mem[1] = 32'hDEADBEEF;
    n_tests++;
    if ({resp, lat, nstb} !== {OKAY, 32'd2, 32'd1}) begin
      n_fail++; $display("FAIL write_004: resp=%b lat=%0d strobes=%0d expected 00 2 1", resp, lat, nstb);
    end
    n_tests++;
    if (mon_addr !== 8'd1) begin
      n_fail++; $display("FAIL write_004_addr: got %0d expected 1", mon_addr);
    end
    do_read(12'h004, resp, d, lat, nstb);
    n_tests++;
    if ({resp, d, lat, nstb} !== {OKAY, ref_mem[1], 32'd3, 32'd1}) begin
      n_fail++; $display("FAIL read_004: resp=%b data=%h lat=%0d strobes=%0d expected 00 %h 3 1",
                         resp, d, lat, nstb, ref_mem[1]);
    end
  endtask

  task automatic test_bad_write();
    logic [1:0] resp; logic [31:0] d; int lat, nstb;
    do_write(12'h008, 32'h0BAD0BAD, 4'h3, resp, lat, nstb);
    n_tests++;
    if ({resp, lat, nstb} !== {SLVERR, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL write_partial: resp=%b lat=%0d strobes=%0d expected 10 1 0", resp, lat, nstb);
    end
    do_write(12'h002, 32'h12345678, 4'hF, resp, lat, nstb);
    n_tests++;
    if ({resp, lat, nstb} !== {SLVERR, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL write_misaligned: resp=%b lat=%0d strobes=%0d expected 10 1 0", resp, lat, nstb);
    end
    do_read(12'h008, resp, d, lat, nstb);
    n_tests++;
    if ({resp, d} !== {OKAY, ref_mem[2]}) begin
      n_fail++; $display("FAIL read_after_bad_write: resp=%b data=%h expected 00 %h", resp, d, ref_mem[2]);
    end
  endtask

  task automatic test_backpressure();
    int hs, lat;
    logic [11:0] a = 12'h004;
    logic [31:0] wd = $urandom;
    logic [33:0] got;
    // Read response held while rready is low; a competing AR must not be taken.
    rq.delete();
    s_rready = 1'b0;
    issue_read(a, hs);
    wait_r(lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL bp_read_lat: got %0d expected 3", lat); end
    s_araddr = 12'h00C; s_arvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if ({s_rvalid, s_rresp, s_rdata, s_arready} !== {1'b1, OKAY, ref_mem[m_idx(a)], 1'b0}) begin
        n_fail++; $display("FAIL bp_rhold[%0d]: rvalid=%b rdata=%h arready=%b expected 1 %h 0",
                           k, s_rvalid, s_rdata, s_arready, ref_mem[m_idx(a)]);
      end
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_rready = 1'b1;
    @(posedge clk); #1;
    got = (rq.size() > 0) ? rq.pop_front() : 34'bx;
    n_tests++;
    if (got !== {OKAY, ref_mem[m_idx(a)]}) begin
      n_fail++; $display("FAIL bp_read_data: got %h expected %h", got, {OKAY, ref_mem[m_idx(a)]});
    end
    @(negedge clk);
    n_tests++;
    if (s_rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_rvalid_drop: got %b expected 0", s_rvalid); end
    @(posedge clk); #1;
    // Write response held while bready is low.
    bq.delete();
    s_bready = 1'b0;
    issue_write(12'h00C, wd, 4'hF, hs);
    ref_mem[3] = wd;
    wait_b(lat);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL bp_write_lat: got %0d expected 2", lat); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if ({s_bvalid, s_bresp} !== {1'b1, OKAY}) begin
        n_fail++; $display("FAIL bp_bhold[%0d]: bvalid=%b bresp=%b expected 1 00", k, s_bvalid, s_bresp);
      end
    end
    @(posedge clk); #1;
    s_bready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bq.size() !== 1) begin n_fail++; $display("FAIL bp_bresp_count: got %0d expected 1", bq.size()); end
    bq.delete();
  endtask

  task automatic test_arbitration();
    for (int round = 0; round < 2; round++) begin
      logic [11:0] wa = 12'(4 * $urandom_range(0, 3));
      logic [11:0] ra = 12'(4 * $urandom_range(4, 7));
      logic [31:0] wd = $urandom;
      logic [1:0]  order = 2'b00;
      logic [1:0]  exp_order = m_last_wr ? 2'b01 : 2'b10;
      logic [31:0] exp_rd = ref_mem[m_idx(ra)];
      int          n_got = 0;
      bit          both = 1'b0;
      bq.delete(); rq.delete();
      s_awaddr = wa; s_wdata = wd; s_wstrb = 4'hF; s_araddr = ra;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      for (int i = 0; i < 60 && n_got < 2; i++) begin
        bit wh, rh;
        @(negedge clk);
        wh = s_awready && s_wready;
        rh = s_arready;
        if (wh && rh) both = 1'b1;
        @(posedge clk); #1;
        if (wh) begin s_awvalid = 1'b0; s_wvalid = 1'b0; order = {order[0], 1'b1}; n_got++; end
        if (rh) begin s_arvalid = 1'b0; order = {order[0], 1'b0}; n_got++; end
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      for (int i = 0; i < 20 && (bq.size() == 0 || rq.size() == 0); i++) @(posedge clk);
      #1;
      ref_mem[m_idx(wa)] = wd;
      m_last_wr = (exp_order[0] == 1'b1);
      n_tests++;
      if ({order, both, n_got} !== {exp_order, 1'b0, 32'd2}) begin
        n_fail++; $display("FAIL arb_order[%0d]: got %b (both=%b n=%0d) expected %b (1=write first)",
                           round, order, both, n_got, exp_order);
      end
      n_tests++;
      if (bq.size() != 1 || rq.size() != 1 || bq[0] !== OKAY || rq[0] !== {OKAY, exp_rd}) begin
        n_fail++; $display("FAIL arb_resp[%0d]: nb=%0d nr=%0d expected one OKAY each with rdata %h",
                           round, bq.size(), rq.size(), exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs [3];
    logic [31:0] wd [3];
    int w0 = wr_strobes;
    bq.delete(); rq.delete();
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      wd[k] = $urandom;
      s_awaddr = 12'(4 * k); s_wdata = wd[k]; hs[k] = -1000;
      for (int i = 0; i < 20 && hs[k] < 0; i++) begin
        @(negedge clk);
        if (s_awready) hs[k] = cyc;
      end
      @(posedge clk); #1;
      ref_mem[k] = wd[k];
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    m_last_wr = 1'b1;
    for (int i = 0; i < 20 && bq.size() < 3; i++) @(posedge clk);
    #1;
    n_tests++;
    if ({hs[1] - hs[0], hs[2] - hs[1], wr_strobes - w0} !== {32'd3, 32'd3, 32'd3}) begin
      n_fail++; $display("FAIL b2b_write_spacing: gaps %0d %0d strobes %0d expected 3 3 3",
                         hs[1] - hs[0], hs[2] - hs[1], wr_strobes - w0);
    end
    s_arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_araddr = 12'(4 * k); hs[k] = -1000;
      for (int i = 0; i < 20 && hs[k] < 0; i++) begin
        @(negedge clk);
        if (s_arready) hs[k] = cyc;
      end
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
    m_last_wr = 1'b0;
    for (int i = 0; i < 20 && rq.size() < 3; i++) @(posedge clk);
    #1;
    n_tests++;
    if ({hs[1] - hs[0], hs[2] - hs[1]} !== {32'd4, 32'd4}) begin
      n_fail++; $display("FAIL b2b_read_spacing: gaps %0d %0d expected 4 4", hs[1] - hs[0], hs[2] - hs[1]);
    end
    for (int k = 0; k < 3; k++) begin
      logic [33:0] got = (rq.size() > 0) ? rq.pop_front() : 34'bx;
      n_tests++;
      if (got !== {OKAY, ref_mem[k]}) begin
        n_fail++; $display("FAIL b2b_read_data[%0d]: got %h expected %h", k, got, {OKAY, ref_mem[k]});
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int hs, lat, nstb;
    logic [1:0] resp; logic [31:0] d;
    rq.delete();
    issue_read(12'h004, hs);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata,
         sram_cs, sram_we, sram_addr, sram_din} !== 83'd0) begin
      n_fail++; $display("FAIL rst_mid_read: cs=%b rv=%b addr=%h rdata=%h expected all 0",
                         sram_cs, s_rvalid, sram_addr, s_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_last_wr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (rq.size() !== 0) begin n_fail++; $display("FAIL rst_resp_lost: got %0d responses expected 0", rq.size()); end
    do_read(12'h004, resp, d, lat, nstb);
    n_tests++;
    if ({resp, d, lat, nstb} !== {OKAY, ref_mem[1], 32'd3, 32'd1}) begin
      n_fail++; $display("FAIL read_after_rst: resp=%b data=%h lat=%0d strobes=%0d expected 00 %h 3 1",
                         resp, d, lat, nstb, ref_mem[1]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [11:0] a;
      logic [3:0]  st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      logic [31:0] wd = $urandom;
      logic [1:0]  resp; logic [31:0] d; int lat, nstb;
      int          sel = $urandom_range(0, 9);
      if (sel <= 5)      a = 12'(4 * $urandom_range(0, DEPTH - 1));
      else if (sel == 6) a = 12'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else if (sel == 7) a = 12'(4 * $urandom_range(DEPTH, 255));
      else if (sel == 8) a = 12'h400 | 12'($urandom_range(0, 1023));
      else               a = 12'h020;
      if ($urandom_range(0, 1) == 1) begin
        bit good = m_addr_ok(a) && (st == 4'hF);
        do_write(a, wd, st, resp, lat, nstb);
        if (good) ref_mem[m_idx(a)] = wd;
        n_tests++;
        if ({resp, lat, nstb} !== (good ? {OKAY, 32'd2, 32'd1} : {SLVERR, 32'd1, 32'd0})) begin
          n_fail++; $display("FAIL rnd_write[%0d] addr=%h strb=%h: resp=%b lat=%0d strobes=%0d expected ok=%b",
                             t, a, st, resp, lat, nstb, good);
        end
        if (good) begin
          n_tests++;
          if (mon_addr !== 8'(m_idx(a))) begin
            n_fail++; $display("FAIL rnd_write_addr[%0d]: got %0d expected %0d", t, mon_addr, m_idx(a));
          end
        end
      end else begin
        bit good = m_addr_ok(a);
        logic [31:0] exp_d = good ? ref_mem[m_idx(a)] : 32'd0;
        do_read(a, resp, d, lat, nstb);
        n_tests++;
        if ({resp, d, lat, nstb} !== (good ? {OKAY, exp_d, 32'd3, 32'd1} : {SLVERR, 32'd0, 32'd1, 32'd0})) begin
          n_fail++; $display("FAIL rnd_read[%0d] addr=%h: resp=%b data=%h lat=%0d strobes=%0d expected ok=%b data=%h",
                             t, a, resp, d, lat, nstb, good, exp_d);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_decode();
    test_write_read();
    test_bad_write();
    test_backpressure();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
